// File: rtl/firefly_flash_sched.sv
// Round-robin scheduler that shares one flash emitter among four fireflies: IDLE -> FLASH -> GAP -> IDLE.
// Optional macro FIREFLY_SCHED_QUEEN_PRIO_EN gives req[0] (the queen) absolute priority.
module firefly_flash_sched #(
  parameter int FLASH_LEN = 15000,
  parameter int GAP_LEN   = 2500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       flash,
  output logic [3:0] grant,
  output logic [1:0] active_id,
  output logic [3:0] done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [13:0] FLASH_LAST = 14'(FLASH_LEN - 1);
  localparam logic [13:0] GAP_LAST   = (GAP_LEN > 0) ? 14'(GAP_LEN - 1) : 14'd0;
  localparam logic [13:0] CNT_MAX    = 14'h3fff;
  localparam bit          GAP_EN     = (GAP_LEN != 0);

  state_t      state_r, state_s;
  logic [13:0] cnt_r, cnt_s;
  logic [3:0]  grant_r, grant_s;
  logic [3:0]  done_r, done_s;
  logic [1:0]  id_r, id_s;
  logic [1:0]  ptr_r, ptr_s;
  logic        flash_r, flash_s;
  logic        busy_r, busy_s;
  logic        arm_r;
  logic [2:0]  pick_s;
  logic        queen_s;

  // First asserted bit at or after start, wrapping; result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration; a queen win leaves the pointer alone so bits 1..3 keep their rotation.
  always_comb begin
    pick_s  = 3'b000;
    queen_s = 1'b0;
`ifdef FIREFLY_SCHED_QUEEN_PRIO_EN
    if (req[0]) begin
      pick_s  = 3'b100;
      queen_s = 1'b1;
    end else begin
      pick_s  = rr_pick(req & 4'b1110, ptr_r);
      queen_s = 1'b0;
    end
`else
    pick_s  = rr_pick(req, ptr_r);
    queen_s = 1'b0;
`endif
  end

  // Next-state and next-output logic for the flash FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 14'd1;
    grant_s = grant_r;
    flash_s = flash_r;
    done_s  = 4'b0000;
    busy_s  = busy_r;
    id_s    = id_r;
    ptr_s   = ptr_r;
    case (state_r)
      IDLE: begin
        // arm_r holds off arbitration for the first edge after reset release.
        if (arm_r && pick_s[2]) begin
          state_s = FLASH;
          cnt_s   = 14'd0;
          grant_s = 4'b0001 << pick_s[1:0];
          flash_s = 1'b1;
          busy_s  = 1'b1;
          id_s    = pick_s[1:0];
          ptr_s   = queen_s ? ptr_r : pick_s[1:0] + 2'd1;
        end else begin
          state_s = IDLE;
        end
      end
      FLASH: begin
        if (cnt_r >= FLASH_LAST) begin
          grant_s = 4'b0000;
          flash_s = 1'b0;
          done_s  = grant_r;
          cnt_s   = 14'd0;
          if (GAP_EN) begin
            state_s = GAP;
            busy_s  = 1'b1;
          end else begin
            state_s = IDLE;
            busy_s  = 1'b0;
          end
        end else begin
          state_s = FLASH;
        end
      end
      GAP: begin
        if (cnt_r >= GAP_LAST) begin
          state_s = IDLE;
          cnt_s   = 14'd0;
          busy_s  = 1'b0;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 14'd0;
        grant_s = 4'b0000;
        flash_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the emitter without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 14'd0;
      grant_r <= 4'b0000;
      flash_r <= 1'b0;
      done_r  <= 4'b0000;
      busy_r  <= 1'b0;
      id_r    <= 2'd0;
      ptr_r   <= 2'd0;
      arm_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      grant_r <= grant_s;
      flash_r <= flash_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      id_r    <= id_s;
      ptr_r   <= ptr_s;
      arm_r   <= 1'b1;
    end
  end

  assign flash     = flash_r;
  assign grant     = grant_r;
  assign active_id = id_r;
  assign done      = done_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_firefly_flash_sched.sv
// Bench for firefly_flash_sched: vector tables for cycle-exact behaviour plus a grant-order scoreboard.
module tb_firefly_flash_sched;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [3:0] req_a, req_b;
  logic       flash_a, busy_a, flash_b, busy_b;
  logic [3:0] grant_a, done_a, grant_b, done_b;
  logic [1:0] aid_a, aid_b;

  firefly_flash_sched #(.FLASH_LEN(4), .GAP_LEN(2)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req(req_a), .flash(flash_a), .grant(grant_a),
    .active_id(aid_a), .done(done_a), .busy(busy_a)
  );

  firefly_flash_sched #(.FLASH_LEN(1), .GAP_LEN(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req(req_b), .flash(flash_b), .grant(grant_b),
    .active_id(aid_b), .done(done_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic       flash;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] done;
    logic [1:0] aid;
  } vec_t;

  vec_t vecs[16];
  int   nvec = 0;
  bit   sel_b = 1'b0;

  task automatic add(input logic [3:0] r, input logic f, input logic [3:0] g,
                     input logic b, input logic [3:0] d, input logic [1:0] id);
    vecs[nvec] = '{r, f, g, b, d, id};
    nvec++;
  endtask

  // Each row: drive req, let one rising edge pass, sample on the falling edge.
  task automatic run_vecs(input string tag);
    logic       of, ob;
    logic [3:0] og, od;
    logic [1:0] oid;
    for (int i = 0; i < nvec; i++) begin
      if (sel_b) req_b = vecs[i].req;
      else       req_a = vecs[i].req;
      @(negedge clk);
      of  = sel_b ? flash_b : flash_a;
      ob  = sel_b ? busy_b  : busy_a;
      og  = sel_b ? grant_b : grant_a;
      od  = sel_b ? done_b  : done_a;
      oid = sel_b ? aid_b   : aid_a;
      check($sformatf("%s[%0d].flash", tag, i), 32'(of), 32'(vecs[i].flash));
      check($sformatf("%s[%0d].grant", tag, i), 32'(og), 32'(vecs[i].grant));
      check($sformatf("%s[%0d].busy", tag, i), 32'(ob), 32'(vecs[i].busy));
      check($sformatf("%s[%0d].done", tag, i), 32'(od), 32'(vecs[i].done));
      check($sformatf("%s[%0d].active_id", tag, i), 32'(oid), 32'(vecs[i].aid));
    end
    nvec = 0;
  endtask

  // Scoreboard of expected grants on dut_a, popped at each new grant; also checks flash length.
  logic [3:0] sb[$];
  logic [3:0] prev_g;
  logic [3:0] sb_exp;
  int         flen;

  always @(negedge clk) begin
    if (!rst_n_a) begin
      prev_g = 4'b0000;
      flen   = 0;
    end else begin
      if (grant_a != 4'b0000 && prev_g == 4'b0000) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_grant", 32'(grant_a), 32'd0);
        end else begin
          sb_exp = sb.pop_front();
          check("sb_grant", 32'(grant_a), 32'(sb_exp));
        end
      end
      if (flash_a) begin
        flen++;
      end else if (flen != 0) begin
        check("flash_len", 32'(flen), 32'd4);
        flen = 0;
      end
      prev_g = grant_a;
    end
  end

  task automatic wait_sb();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("sb_timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    req_a   = 4'b0000;
    req_b   = 4'b0000;
    repeat (2) @(negedge clk);

    check("rst_a.flash", 32'(flash_a), 32'd0);
    check("rst_a.grant", 32'(grant_a), 32'd0);
    check("rst_a.busy", 32'(busy_a), 32'd0);
    check("rst_a.done", 32'(done_a), 32'd0);
    check("rst_a.active_id", 32'(aid_a), 32'd0);
    check("rst_b.flash", 32'(flash_b), 32'd0);
    check("rst_b.grant", 32'(grant_b), 32'd0);

    // Single requester: no grant on first edge after release, 4 flash, 2 gap, 1 idle, regrant.
    rst_n_a = 1'b1;
    sb.push_back(4'b0001);
    sb.push_back(4'b0001);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0);
    add(4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    add(4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    add(4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    add(4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    add(4'b0001, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0);
    add(4'b0001, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0);
    add(4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0);
    add(4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    run_vecs("t1");
    req_a = 4'b0000;
    wait_sb();

    // All four requesting from a fresh reset, then the queen drops out.
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    req_a   = 4'b1111;
`ifdef FIREFLY_SCHED_QUEEN_PRIO_EN
    repeat (5) sb.push_back(4'b0001);
`else
    sb.push_back(4'b0001);
    sb.push_back(4'b0010);
    sb.push_back(4'b0100);
    sb.push_back(4'b1000);
    sb.push_back(4'b0001);
`endif
    wait_sb();
    req_a = 4'b1110;
    sb.push_back(4'b0010);
    sb.push_back(4'b0100);
    sb.push_back(4'b1000);
    wait_sb();
    req_a = 4'b0000;
    repeat (10) @(negedge clk);

    // One-cycle request pulse still yields a full flash.
    req_a = 4'b0100;
    sb.push_back(4'b0100);
    @(negedge clk);
    req_a = 4'b0000;
    check("t3.grant", 32'(grant_a), 32'h4);
    check("t3.active_id", 32'(aid_a), 32'd2);
    repeat (3) @(negedge clk);
    check("t3.flash_last", 32'(flash_a), 32'd1);
    @(negedge clk);
    check("t3.done", 32'(done_a), 32'h4);
    check("t3.flash_off", 32'(flash_a), 32'd0);
    repeat (3) @(negedge clk);
    check("t3.idle_busy", 32'(busy_a), 32'd0);
    check("t3.idle_active_id", 32'(aid_a), 32'd2);
    wait_sb();

    // Reset during the second flash cycle.
    req_a = 4'b1111;
`ifdef FIREFLY_SCHED_QUEEN_PRIO_EN
    sb.push_back(4'b0001);
`else
    sb.push_back(4'b1000);
`endif
    @(negedge clk);
    @(negedge clk);
    check("t4.pre_flash", 32'(flash_a), 32'd1);
    rst_n_a = 1'b0;
    #1;
    check("t4.async_flash", 32'(flash_a), 32'd0);
    check("t4.async_grant", 32'(grant_a), 32'd0);
    check("t4.async_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("t4.no_done", 32'(done_a), 32'd0);
    check("t4.rst_active_id", 32'(aid_a), 32'd0);
    rst_n_a = 1'b1;
    sb.push_back(4'b0001);
    @(negedge clk);
    check("t4.no_done_after", 32'(done_a), 32'd0);
    wait_sb();
    req_a = 4'b0000;
    wait_sb();

    // Zero gap, one-cycle flash, two requesters.
    rst_n_b = 1'b1;
    repeat (2) @(negedge clk);
    sel_b = 1'b1;
`ifdef FIREFLY_SCHED_QUEEN_PRIO_EN
    add(4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    add(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0001, 2'd0);
    add(4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    add(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0001, 2'd0);
`else
    add(4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    add(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0001, 2'd0);
    add(4'b0011, 1'b1, 4'b0010, 1'b1, 4'b0000, 2'd1);
    add(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0010, 2'd1);
    add(4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0);
    add(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0001, 2'd0);
`endif
    run_vecs("t5");
    req_b = 4'b0000;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/firefly_flash_sched.md
FIREFLY_FLASH_SCHED -- requirements
Module: firefly_flash_sched

Interface
REQ-001 The block SHALL have parameter FLASH_LEN, default 15000, giving the flash length in clk cycles (legal range 1..16383).
REQ-002 The block SHALL have parameter GAP_LEN, default 2500, giving the dark gap after each flash in clk cycles (legal range 0..16383).
REQ-003 The block SHALL have port clk, input, 1 bit: the 50 MHz system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 4 bits: level flash requests, one bit per firefly, bit 0 being the queen.
REQ-006 The block SHALL have port flash, output, 1 bit: drive to the shared flash emitter.
REQ-007 The block SHALL have port grant, output, 4 bits: one-hot owner of the current flash, all zeros otherwise.
REQ-008 The block SHALL have port active_id, output, 2 bits: binary index of the last granted requester.
REQ-009 The block SHALL have port done, output, 4 bits: one-cycle pulse on the owner's bit when its flash completes.
REQ-010 The block SHALL have port busy, output, 1 bit: high in the FLASH and GAP states.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, FLASH and GAP, plus a 14-bit cycle counter cnt.
REQ-012 In IDLE with req != 0, the block SHALL enter FLASH on the next edge, with grant, flash, busy and active_id updated on that same edge and cnt=0.
REQ-013 flash SHALL be high for exactly FLASH_LEN consecutive cycles per grant, with grant held constant throughout.
REQ-014 On the edge ending the last FLASH cycle, grant and flash SHALL go low, done[owner] SHALL pulse for one cycle, and the FSM SHALL enter GAP, or IDLE if GAP_LEN=0.
REQ-015 GAP SHALL last exactly GAP_LEN cycles with flash=0, then the FSM SHALL return to IDLE; a new grant therefore needs one IDLE cycle.
REQ-016 Arbitration SHALL be round-robin: the search starts at the index after the last grant, and the first asserted req bit wins.
REQ-017 After reset the round-robin pointer SHALL make index 0 the first candidate.
REQ-018 Deasserting req during FLASH or GAP SHALL NOT abort or shorten the flash; requests are sampled only in IDLE.
REQ-019 A requester holding req high across done SHALL be re-served only after every other asserted requester has been served.
REQ-020 cnt SHALL saturate and never wrap; it SHALL clear on every state entry.
REQ-021 active_id SHALL retain its value through GAP and IDLE.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, cnt=0, flash=0, grant=0, done=0, busy=0, active_id=0 and the round-robin pointer to index 0.
REQ-023 Reset asserted mid-FLASH SHALL drop flash asynchronously, with no done pulse.
REQ-024 After rst_n deasserts, the first grant SHALL be issued no earlier than the second rising edge.

Configuration
REQ-025 With macro FIREFLY_SCHED_QUEEN_PRIO_EN defined, req[0] SHALL win any IDLE arbitration in which it is asserted, and the other bits SHALL remain round-robin among themselves.
REQ-026 Without FIREFLY_SCHED_QUEEN_PRIO_EN, all four bits SHALL be pure round-robin per REQ-016.

Verification
REQ-027 The bench SHALL cover: FLASH_LEN=4, GAP_LEN=2, req=0001 held → flash high for 4 cycles, done[0] pulses once, busy lasts 6 cycles, and the next flash starts 7 cycles after the first.
REQ-028 The bench SHALL cover: req=1111 held, macro undefined → grant order 0001, 0010, 0100, 1000, 0001.
REQ-029 The bench SHALL cover: req=1111 held, macro defined → grant 0001 every slot; then req=1110 → grant order 0010, 0100, 1000.
REQ-030 The bench SHALL cover: req[2] pulsed for 1 IDLE cycle → a full 4-cycle flash with grant=0100, active_id=2, and done[2] pulse.
REQ-031 The bench SHALL cover: rst_n pulled low at cycle 2 of a flash → flash, grant and busy go 0 immediately, with no done pulse, and the next grant goes to index 0.
REQ-032 The bench SHALL cover: GAP_LEN=0, FLASH_LEN=1, req=0011 → flash high 1 cycle, low 1 cycle, and so on, with grant alternating 0001 and 0010.
